// File: rtl/vape_pkg.sv
// Shared definitions for the VAPE monitor family: FSM encoding, default widths
// and the protected address ranges also used by the immutability monitor.
package vape_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FAIL = 2'd3
    } vape_state_t;

    localparam int CNT_W_DEF = 8;

    localparam logic [15:0] METADATA_MIN = 16'h0140;
    localparam logic [15:0] METADATA_MAX = 16'h0160;
    localparam logic [15:0] IVT_MIN      = 16'hFFE0;
    localparam logic [15:0] IVT_MAX      = 16'hFFFF;

    function automatic logic in_range(input logic [15:0] a,
                                      input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/vape_exec_flag_if.sv
// Attestation snapshot handshake between the attestation engine (master)
// and the EXEC flag block (slave).
interface vape_exec_flag_if #(parameter int CNT_W = vape_pkg::CNT_W_DEF) ();
    logic             att_req;
    logic             att_ack;
    logic             att_valid;
    logic             att_exec;
    logic [CNT_W-1:0] att_count;

    modport master (output att_req, att_ack,
                    input  att_valid, att_exec, att_count);
    modport slave  (input  att_req, att_ack,
                    output att_valid, att_exec, att_count);
endinterface

// File: rtl/vape_att_snapshot.sv
// Req/valid/ack register slice: captures flag and count on request and holds
// them stable until the attestation engine acknowledges.
module vape_att_snapshot #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_req,
    input  logic             i_ack,
    input  logic             i_exec,
    input  logic [CNT_W-1:0] i_count,
    output logic             o_valid,
    output logic             o_exec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_ack_taken
);
    logic             r_valid;
    logic             r_exec;
    logic [CNT_W-1:0] r_count;

    assign o_valid     = r_valid;
    assign o_exec      = r_exec;
    assign o_count     = r_count;
    assign o_ack_taken = r_valid & i_ack;

    // While valid, a request is ignored; an ack drops valid (and wins over a request).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_exec  <= 1'b0;
            r_count <= '0;
        end else if (r_valid) begin
            if (i_ack) r_valid <= 1'b0;
        end else if (i_req) begin
            r_valid <= 1'b1;
            r_exec  <= i_exec;
            r_count <= i_count;
        end
    end

endmodule

// File: rtl/vape_exec_flag.sv
// Tracks whole-run execution of the Executable Region, producing a sticky EXEC
// flag and a saturating completed-run counter, snapshotted for attestation.
module vape_exec_flag
    import vape_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter bit CLEAR_ON_ACK = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       pc,
    input  logic [15:0]       ER_min,
    input  logic [15:0]       ER_max,
    input  logic              exec_immut,
    input  logic              exec_atomic,
    input  logic              exec_outp,
    input  logic              irq,
    output logic              exec_flag,
    output logic [CNT_W-1:0]  run_count,
    vape_exec_flag_if.slave   att
);
    vape_state_t      r_state;
    logic [15:0]      r_prev_pc;
    logic             r_exec_flag;
    logic [CNT_W-1:0] r_run_count;

    vape_state_t w_next_fsm;
    vape_state_t w_next;
    logic        w_inc;
    logic        w_ack_taken;
    logic        w_clear;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    wire w_exec_all    = exec_immut & exec_atomic & exec_outp;
    wire w_in_er       = in_range(pc, ER_min, ER_max);
    wire w_prev_in_er  = in_range(r_prev_pc, ER_min, ER_max);
    wire w_cfg_bad     = ER_min > ER_max;
    // prev_pc inside ER suppresses entry: covers loops back to ER_min and stalled pc.
    wire w_fresh_entry = (pc == ER_min) && !w_prev_in_er && w_exec_all;
    wire w_mid_entry   = w_in_er && (pc != ER_min) && !w_prev_in_er;

    assign w_clear = CLEAR_ON_ACK && w_ack_taken;

    always_comb begin
        w_next_fsm = r_state;
        w_inc      = 1'b0;
        if (w_cfg_bad) begin
            w_next_fsm = ST_FAIL;
        end else if (w_fresh_entry) begin
            w_next_fsm = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!w_exec_all || irq) begin
                        w_next_fsm = ST_FAIL;
                    end else if (!w_in_er) begin
                        if (r_prev_pc == ER_max) begin
                            w_next_fsm = ST_DONE;
                            w_inc      = 1'b1;
                        end else begin
                            w_next_fsm = ST_FAIL;
                        end
                    end
                end
                ST_DONE: begin
                    if (!w_exec_all || w_mid_entry) w_next_fsm = ST_FAIL;
                end
                ST_IDLE: begin
                    if (w_mid_entry) w_next_fsm = ST_FAIL;
                end
                default: w_next_fsm = r_state;
            endcase
        end
    end

    // The ack clear only retires a DONE that nothing else moved this cycle.
    always_comb begin
        w_next = w_next_fsm;
        if (w_clear && (r_state == ST_DONE) && (w_next_fsm == ST_DONE))
            w_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_prev_pc   <= 16'h0000;
            r_exec_flag <= 1'b0;
            r_run_count <= '0;
        end else begin
            r_state     <= w_next;
            r_prev_pc   <= pc;
            r_exec_flag <= (w_next == ST_DONE);
            if (w_clear)
                r_run_count <= '0;
            else if (w_inc)
                r_run_count <= sat_inc(r_run_count);
        end
    end

    assign exec_flag = r_exec_flag;
    assign run_count = r_run_count;

    vape_att_snapshot #(.CNT_W(CNT_W)) u_snap (
        .clk         (clk),
        .reset       (reset),
        .i_req       (att.att_req),
        .i_ack       (att.att_ack),
        .i_exec      (r_exec_flag),
        .i_count     (r_run_count),
        .o_valid     (att.att_valid),
        .o_exec      (att.att_exec),
        .o_count     (att.att_count),
        .o_ack_taken (w_ack_taken)
    );

endmodule

// File: tb/tb_vape_exec_flag.sv
// Directed bench for vape_exec_flag: legitimate runs, violations, attestation
// handshake, saturation, asynchronous reset and bad configuration.
module tb_vape_exec_flag;
    import vape_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic [15:0] ER_min;
    logic [15:0] ER_max;
    logic        exec_immut;
    logic        exec_atomic;
    logic        exec_outp;
    logic        irq;
    logic        exec_flag;
    logic [7:0]  run_count;

    int n_pass  = 0;
    int n_total = 0;

    vape_exec_flag_if #(.CNT_W(8)) att ();

    vape_exec_flag #(.CNT_W(8), .CLEAR_ON_ACK(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .ER_min      (ER_min),
        .ER_max      (ER_max),
        .exec_immut  (exec_immut),
        .exec_atomic (exec_atomic),
        .exec_outp   (exec_outp),
        .irq         (irq),
        .exec_flag   (exec_flag),
        .run_count   (run_count),
        .att         (att.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input logic [15:0] p);
        pc = p;
        @(posedge clk);
        #1;
    endtask

    task automatic run_er();
        step(16'hE000);
        step(16'hE010);
        step(16'hE0FE);
        step(16'h4400);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pc    = 16'h4400;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        pc          = 16'h4400;
        ER_min      = 16'hE000;
        ER_max      = 16'hE0FE;
        exec_immut  = 1'b1;
        exec_atomic = 1'b1;
        exec_outp   = 1'b1;
        irq         = 1'b0;
        att.att_req = 1'b0;
        att.att_ack = 1'b0;
        #1;
        chk("rst_flag",  exec_flag, 0);
        chk("rst_count", run_count, 0);
        chk("rst_valid", att.att_valid, 0);
        chk("rst_aexec", att.att_exec, 0);
        chk("rst_acnt",  att.att_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: legitimate run
        step(16'h4400);
        step(16'hE000);
        chk("t1_run_flag", exec_flag, 0);
        step(16'hE010);
        step(16'hE0FE);
        chk("t1_pre_exit", exec_flag, 0);
        step(16'h4400);
        chk("t1_flag",  exec_flag, 1);
        chk("t1_count", run_count, 1);

        // 2: immutability violation then retry
        do_reset();
        step(16'hE000);
        exec_immut = 1'b0;
        step(16'hE010);
        exec_immut = 1'b1;
        step(16'hE0FE);
        step(16'h4400);
        chk("t2_fail_flag",  exec_flag, 0);
        chk("t2_fail_count", run_count, 0);
        run_er();
        chk("t2_retry_flag",  exec_flag, 1);
        chk("t2_retry_count", run_count, 1);

        // 3: mid-region entry, illegal exit, interrupt
        step(16'hE020);
        chk("t3_mid_entry", exec_flag, 0);
        step(16'h4400);
        step(16'hE000);
        step(16'hE050);
        step(16'h4400);
        chk("t3_bad_exit", exec_flag, 0);
        step(16'hE000);
        irq = 1'b1;
        step(16'hE010);
        irq = 1'b0;
        step(16'hE0FE);
        step(16'h4400);
        chk("t3_irq_flag",  exec_flag, 0);
        chk("t3_irq_count", run_count, 1);

        // 4: stalled pc and loop back to ER_min are legal; post-run tampering clears flag
        step(16'hE000);
        step(16'hE010);
        step(16'hE010);
        step(16'hE000);
        step(16'hE0FE);
        step(16'h4400);
        chk("t4_flag",  exec_flag, 1);
        chk("t4_count", run_count, 2);
        exec_outp = 1'b0;
        step(16'h4402);
        exec_outp = 1'b1;
        chk("t4_tamper", exec_flag, 0);
        step(16'h4404);
        chk("t4_sticky", exec_flag, 0);

        // 5: attestation snapshot
        do_reset();
        run_er();
        run_er();
        run_er();
        chk("t5_count3", run_count, 3);
        att.att_req = 1'b1;
        step(16'h4400);
        att.att_req = 1'b0;
        chk("t5_valid", att.att_valid, 1);
        chk("t5_aexec", att.att_exec, 1);
        chk("t5_acnt",  att.att_count, 3);
        step(16'h4402);
        step(16'h4404);
        chk("t5_hold_valid", att.att_valid, 1);
        chk("t5_hold_acnt",  att.att_count, 3);
        chk("t5_hold_aexec", att.att_exec, 1);
        att.att_ack = 1'b1;
        step(16'h4404);
        att.att_ack = 1'b0;
        chk("t5_ack_valid", att.att_valid, 0);
        chk("t5_ack_count", run_count, 0);
        chk("t5_ack_flag",  exec_flag, 0);
        run_er();
        att.att_ack = 1'b1;
        step(16'h4400);
        att.att_ack = 1'b0;
        chk("t5_stray_ack_count", run_count, 1);
        chk("t5_stray_ack_flag",  exec_flag, 1);
        // ack lands in the cycle the run completes
        step(16'hE000);
        att.att_req = 1'b1;
        step(16'hE010);
        att.att_req = 1'b0;
        chk("t5_run_aexec", att.att_exec, 0);
        chk("t5_run_acnt",  att.att_count, 1);
        step(16'hE0FE);
        att.att_ack = 1'b1;
        step(16'h4400);
        att.att_ack = 1'b0;
        chk("t5_ackdone_flag",  exec_flag, 1);
        chk("t5_ackdone_count", run_count, 0);
        chk("t5_ackdone_valid", att.att_valid, 0);
        // simultaneous req and ack: ack honoured, req dropped
        att.att_req = 1'b1;
        step(16'h4400);
        chk("t5_req_again", att.att_valid, 1);
        att.att_ack = 1'b1;
        step(16'h4400);
        att.att_ack = 1'b0;
        chk("t5_req_ack_valid", att.att_valid, 0);
        step(16'h4400);
        att.att_req = 1'b0;
        chk("t5_rereq_valid", att.att_valid, 1);
        chk("t5_rereq_aexec", att.att_exec, 0);
        att.att_ack = 1'b1;
        step(16'h4400);
        att.att_ack = 1'b0;

        // 6: saturation, async reset mid-run, bad configuration
        do_reset();
        for (int i = 0; i < 300; i++) run_er();
        chk("t6_sat_count", run_count, 8'hFF);
        chk("t6_sat_flag",  exec_flag, 1);
        att.att_req = 1'b1;
        step(16'h4400);
        att.att_req = 1'b0;
        chk("t6_pre_valid", att.att_valid, 1);
        step(16'hE000);
        step(16'hE010);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_arst_flag",  exec_flag, 0);
        chk("t6_arst_count", run_count, 0);
        chk("t6_arst_valid", att.att_valid, 0);
        chk("t6_arst_acnt",  att.att_count, 0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        ER_min = 16'hF000;
        ER_max = 16'hE000;
        step(16'h4400);
        step(16'hF000);
        step(16'hE000);
        chk("t6_cfg_mid", exec_flag, 0);
        step(16'hE800);
        step(16'hF000);
        step(16'h4400);
        chk("t6_cfg_flag",  exec_flag, 0);
        chk("t6_cfg_count", run_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
